// File: rtl/wb_commit_if.sv
// Bundle of MM2->WB pipeline register outputs plus the stage's back-pressure signal.
interface wb_commit_if;
  logic        wb_valid;
  logic        flush;
  logic        wb_ready;
  logic [31:0] wb_exe_out;
  logic [31:0] wb_rdata;
  logic [1:0]  wb_mm_access_sz;
  logic [7:0]  wb_op;
  logic [3:0]  wb_op_type;
  logic [4:0]  wb_reg_d;
  logic        wb_reg_d_wen;
  logic [31:0] wb_pc;
  logic [13:0] wb_csr_addr;
  logic [31:0] wb_csr_wdata;
  logic [31:0] wb_csr_wmask;

  modport master (
    output wb_valid, flush, wb_exe_out, wb_rdata, wb_mm_access_sz, wb_op,
           wb_op_type, wb_reg_d, wb_reg_d_wen, wb_pc, wb_csr_addr,
           wb_csr_wdata, wb_csr_wmask,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, flush, wb_exe_out, wb_rdata, wb_mm_access_sz, wb_op,
           wb_op_type, wb_reg_d, wb_reg_d_wen, wb_pc, wb_csr_addr,
           wb_csr_wdata, wb_csr_wmask,
    output wb_ready
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: load align/extend, GPR write, 3-cycle masked CSR read-modify-write,
// retire counter. Define WB_TRACE_EN to add the retire trace port.
module wb_commit #(
  parameter logic [3:0] OPT_LOAD = 4'h2,
  parameter logic [3:0] OPT_CSR  = 4'h6,
  parameter int         CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_commit_if.slave        wb,
  output logic              csr_re,
  output logic [13:0]       csr_raddr,
  input  logic [31:0]       csr_rdata,
  output logic              csr_we,
  output logic [13:0]       csr_waddr,
  output logic [31:0]       csr_wdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic              trace_wen,
  output logic [4:0]        trace_waddr,
  output logic [31:0]       trace_wdata
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CSR_RD = 2'd1;
  localparam logic [1:0] S_CSR_WR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             csr_re_q, csr_re_d;
  logic [13:0]      csr_raddr_q, csr_raddr_d;
  logic             csr_we_q, csr_we_d;
  logic [13:0]      csr_waddr_q, csr_waddr_d;
  logic [31:0]      csr_wdata_q, csr_wdata_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lat_wdata_q, lat_wdata_d;
  logic [31:0]      lat_wmask_q, lat_wmask_d;
  logic [4:0]       lat_reg_d_q, lat_reg_d_d;
  logic             lat_wen_q, lat_wen_d;
`ifdef WB_TRACE_EN
  logic [31:0]      lat_pc_q, lat_pc_d;
  logic             trace_valid_q, trace_valid_d;
  logic [31:0]      trace_pc_q, trace_pc_d;
  logic             trace_wen_q, trace_wen_d;
  logic [4:0]       trace_waddr_q, trace_waddr_d;
  logic [31:0]      trace_wdata_q, trace_wdata_d;
  logic             unused_bits;
  assign unused_bits = ^wb.wb_op[7:1];
`else
  logic             unused_bits;
  assign unused_bits = ^{wb.wb_op[7:1], wb.wb_pc};
`endif

  logic        accept;
  logic        is_csr;
  logic        is_load;
  logic [15:0] shifted;
  logic [31:0] load_val;

  assign accept  = wb.wb_valid & ready_q & ~wb.flush;
  assign is_csr  = (wb.wb_op_type == OPT_CSR);
  assign is_load = (wb.wb_op_type == OPT_LOAD);

  // Word accesses ignore the byte offset; sub-word accesses take the shifted low lane.
  always_comb begin
    shifted = 16'(wb.wb_rdata >> {wb.wb_exe_out[1:0], 3'b000});
    case (wb.wb_mm_access_sz)
      2'b00:   load_val = wb.wb_op[0] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = wb.wb_op[0] ? {16'h0, shifted}
                                      : {{16{shifted[15]}}, shifted};
      default: load_val = wb.wb_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    csr_re_d    = 1'b0;
    csr_raddr_d = csr_raddr_q;
    csr_we_d    = 1'b0;
    csr_waddr_d = csr_waddr_q;
    csr_wdata_d = csr_wdata_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    cnt_d       = cnt_q;
    lat_wdata_d = lat_wdata_q;
    lat_wmask_d = lat_wmask_q;
    lat_reg_d_d = lat_reg_d_q;
    lat_wen_d   = lat_wen_q;
`ifdef WB_TRACE_EN
    lat_pc_d      = lat_pc_q;
    trace_valid_d = 1'b0;
    trace_pc_d    = trace_pc_q;
    trace_wen_d   = trace_wen_q;
    trace_waddr_d = trace_waddr_q;
    trace_wdata_d = trace_wdata_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_csr) begin
            state_d     = S_CSR_RD;
            ready_d     = 1'b0;
            csr_re_d    = 1'b1;
            csr_raddr_d = wb.wb_csr_addr;
            lat_wdata_d = wb.wb_csr_wdata;
            lat_wmask_d = wb.wb_csr_wmask;
            lat_reg_d_d = wb.wb_reg_d;
            lat_wen_d   = wb.wb_reg_d_wen;
`ifdef WB_TRACE_EN
            lat_pc_d    = wb.wb_pc;
`endif
          end else begin
            rf_we_d    = wb.wb_reg_d_wen & (wb.wb_reg_d != 5'd0);
            rf_waddr_d = wb.wb_reg_d;
            rf_wdata_d = is_load ? load_val : wb.wb_exe_out;
            cnt_d      = cnt_q + CNT_W'(1);
`ifdef WB_TRACE_EN
            trace_valid_d = 1'b1;
            trace_pc_d    = wb.wb_pc;
            trace_wen_d   = rf_we_d;
            trace_waddr_d = rf_waddr_d;
            trace_wdata_d = rf_wdata_d;
`endif
          end
        end
      end
      S_CSR_RD: begin
        state_d = S_CSR_WR;
      end
      S_CSR_WR: begin
        // csr_rdata answers the read strobe issued one cycle earlier.
        csr_we_d    = (lat_wmask_q != 32'h0);
        csr_waddr_d = csr_raddr_q;
        csr_wdata_d = (csr_rdata & ~lat_wmask_q) | (lat_wdata_q & lat_wmask_q);
        rf_we_d     = lat_wen_q & (lat_reg_d_q != 5'd0);
        rf_waddr_d  = lat_reg_d_q;
        rf_wdata_d  = csr_rdata;
        cnt_d       = cnt_q + CNT_W'(1);
        state_d     = S_IDLE;
        ready_d     = 1'b1;
`ifdef WB_TRACE_EN
        trace_valid_d = 1'b1;
        trace_pc_d    = lat_pc_q;
        trace_wen_d   = rf_we_d;
        trace_waddr_d = rf_waddr_d;
        trace_wdata_d = rf_wdata_d;
`endif
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      csr_re_q    <= 1'b0;
      csr_raddr_q <= '0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      cnt_q       <= '0;
      lat_wdata_q <= '0;
      lat_wmask_q <= '0;
      lat_reg_d_q <= '0;
      lat_wen_q   <= 1'b0;
`ifdef WB_TRACE_EN
      lat_pc_q      <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_wen_q   <= 1'b0;
      trace_waddr_q <= '0;
      trace_wdata_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      csr_re_q    <= csr_re_d;
      csr_raddr_q <= csr_raddr_d;
      csr_we_q    <= csr_we_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wdata_q <= csr_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      cnt_q       <= cnt_d;
      lat_wdata_q <= lat_wdata_d;
      lat_wmask_q <= lat_wmask_d;
      lat_reg_d_q <= lat_reg_d_d;
      lat_wen_q   <= lat_wen_d;
`ifdef WB_TRACE_EN
      lat_pc_q      <= lat_pc_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_wen_q   <= trace_wen_d;
      trace_waddr_q <= trace_waddr_d;
      trace_wdata_q <= trace_wdata_d;
`endif
    end
  end

  assign wb.wb_ready  = ready_q;
  assign csr_re       = csr_re_q;
  assign csr_raddr    = csr_raddr_q;
  assign csr_we       = csr_we_q;
  assign csr_waddr    = csr_waddr_q;
  assign csr_wdata    = csr_wdata_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire_cnt   = cnt_q;
`ifdef WB_TRACE_EN
  assign trace_valid  = trace_valid_q;
  assign trace_pc     = trace_pc_q;
  assign trace_wen    = trace_wen_q;
  assign trace_waddr  = trace_waddr_q;
  assign trace_wdata  = trace_wdata_q;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: table-driven ALU/load vectors, hand-built CSR, flush, reset and
// counter-wrap sequences; GPR writes are checked through an in-order scoreboard.
module tb_wb_commit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_commit_if ifc();
  wb_commit_if ifc4();

  logic        csr_re, csr_we, rf_we;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, rf_wdata;
  logic [4:0]  rf_waddr;
  logic [63:0] retire_cnt;

  logic        csr_re4, csr_we4, rf_we4;
  logic [13:0] csr_raddr4, csr_waddr4;
  logic [31:0] csr_rdata4, csr_wdata4, rf_wdata4;
  logic [4:0]  rf_waddr4;
  logic [3:0]  retire_cnt4;
  assign csr_rdata4 = 32'h0;

`ifdef WB_TRACE_EN
  logic        tv, tw, tv4, tw4;
  logic [31:0] tpc, twd, tpc4, twd4;
  logic [4:0]  twa, twa4;
`endif

  wb_commit #(.CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .wb(ifc.slave),
    .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_cnt(retire_cnt)
`ifdef WB_TRACE_EN
    , .trace_valid(tv), .trace_pc(tpc), .trace_wen(tw), .trace_waddr(twa), .trace_wdata(twd)
`endif
  );

  wb_commit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb(ifc4.slave),
    .csr_re(csr_re4), .csr_raddr(csr_raddr4), .csr_rdata(csr_rdata4),
    .csr_we(csr_we4), .csr_waddr(csr_waddr4), .csr_wdata(csr_wdata4),
    .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .retire_cnt(retire_cnt4)
`ifdef WB_TRACE_EN
    , .trace_valid(tv4), .trace_pc(tpc4), .trace_wen(tw4), .trace_waddr(twa4), .trace_wdata(twd4)
`endif
  );

  // CSR bank: registered read, one cycle after csr_re.
  logic [31:0] bank [16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        bank[i] <= (i == 6) ? 32'hAAAA_AAAA : 32'h1000_0000 + 32'(i);
      csr_rdata <= 32'h0;
    end else begin
      if (csr_we) bank[csr_waddr[3:0]] <= csr_wdata;
      if (csr_re) csr_rdata <= bank[csr_raddr[3:0]];
    end
  end

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic [3:0]  op_type;
    logic [7:0]  op;
    logic [1:0]  sz;
    logic [31:0] exe;
    logic [31:0] rdata;
    logic [4:0]  reg_d;
    logic        wen;
    logic [31:0] pc;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
  } bus_t;

  typedef struct packed {
    bus_t        b;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] cnt;
  } exp_t;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  exp_t        sb[$];
  logic [63:0] exp_cnt  = 64'd0;
  logic [63:0] prev_cnt = 64'd0;
  bus_t        idle = '0;
  vec_t        tbl [12];

  function automatic bus_t mk_alu(input logic [31:0] exe, input logic [4:0] rd, input logic wen);
    bus_t b = '0;
    b.valid = 1'b1; b.op_type = 4'h0; b.exe = exe; b.reg_d = rd; b.wen = wen; b.pc = 32'h100;
    return b;
  endfunction

  function automatic bus_t mk_load(input logic [7:0] op, input logic [1:0] sz,
                                   input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic [4:0] rd);
    bus_t b = '0;
    b.valid = 1'b1; b.op_type = 4'h2; b.op = op; b.sz = sz; b.exe = addr;
    b.rdata = rdata; b.reg_d = rd; b.wen = 1'b1; b.pc = 32'h200;
    return b;
  endfunction

  function automatic bus_t mk_csr(input logic [13:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] mask, input logic [4:0] rd, input logic wen);
    bus_t b = '0;
    b.valid = 1'b1; b.op_type = 4'h6; b.csr_addr = addr; b.csr_wdata = wdata;
    b.csr_wmask = mask; b.reg_d = rd; b.wen = wen; b.pc = 32'h300;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input bus_t b);
    ifc.wb_valid = b.valid;            ifc4.wb_valid = b.valid;
    ifc.flush = b.flush;               ifc4.flush = b.flush;
    ifc.wb_op_type = b.op_type;        ifc4.wb_op_type = b.op_type;
    ifc.wb_op = b.op;                  ifc4.wb_op = b.op;
    ifc.wb_mm_access_sz = b.sz;        ifc4.wb_mm_access_sz = b.sz;
    ifc.wb_exe_out = b.exe;            ifc4.wb_exe_out = b.exe;
    ifc.wb_rdata = b.rdata;            ifc4.wb_rdata = b.rdata;
    ifc.wb_reg_d = b.reg_d;            ifc4.wb_reg_d = b.reg_d;
    ifc.wb_reg_d_wen = b.wen;          ifc4.wb_reg_d_wen = b.wen;
    ifc.wb_pc = b.pc;                  ifc4.wb_pc = b.pc;
    ifc.wb_csr_addr = b.csr_addr;      ifc4.wb_csr_addr = b.csr_addr;
    ifc.wb_csr_wdata = b.csr_wdata;    ifc4.wb_csr_wdata = b.csr_wdata;
    ifc.wb_csr_wmask = b.csr_wmask;    ifc4.wb_csr_wmask = b.csr_wmask;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    exp_t e;
    exp_cnt = exp_cnt + 64'd1;
    e.we = we; e.waddr = waddr; e.wdata = wdata; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic issue(input bus_t b, input logic we, input logic [31:0] wdata);
    drive(b);
    push_exp(we, b.reg_d, wdata);
  endtask

  // A change of retire_cnt marks a retirement; it must match the oldest scoreboard entry.
  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      chk("cnt_in_reset", retire_cnt, 64'd0);
      prev_cnt = 64'd0;
    end else if (retire_cnt !== prev_cnt) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", retire_cnt, prev_cnt);
      end else begin
        e = sb.pop_front();
        chk("rf_we", rf_we, e.we);
        if (e.we) begin
          chk("rf_waddr", rf_waddr, e.waddr);
          chk("rf_wdata", rf_wdata, e.wdata);
        end
        chk("retire_cnt", retire_cnt, e.cnt);
      end
      prev_cnt = retire_cnt;
    end else begin
      chk("rf_we_quiet", rf_we, 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_csr_re"}, csr_re, 0);
    chk({tag, "_csr_raddr"}, csr_raddr, 0);
    chk({tag, "_csr_we"}, csr_we, 0);
    chk({tag, "_csr_waddr"}, csr_waddr, 0);
    chk({tag, "_csr_wdata"}, csr_wdata, 0);
    chk({tag, "_cnt4"}, retire_cnt4, 0);
    chk({tag, "_ready"}, ifc.wb_ready, 1);
  endtask

  // Walks one accepted CSR instruction through its three cycles; 'nxt' goes on the bus
  // while the stage is stalled.
  task automatic csr_run(input logic [13:0] addr, input logic exp_we, input logic [31:0] exp_wd,
                         input bus_t nxt);
    tick();
    chk("csr_re_pulse", csr_re, 1);
    chk("csr_raddr", csr_raddr, addr);
    chk("ready_rd", ifc.wb_ready, 0);
    chk("csr_we_rd", csr_we, 0);
    drive(nxt);
    tick();
    chk("csr_re_off", csr_re, 0);
    chk("ready_wr", ifc.wb_ready, 0);
    chk("csr_we_wr", csr_we, 0);
    tick();
    chk("csr_we", csr_we, exp_we);
    if (exp_we) begin
      chk("csr_waddr", csr_waddr, addr);
      chk("csr_wdata", csr_wdata, exp_wd);
    end
    chk("csr_re_done", csr_re, 0);
    chk("ready_done", ifc.wb_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus_t a, b, c, fl;
    tbl[0]  = '{mk_alu(32'h0000_1234, 5'd5, 1'b1),                          1'b1, 32'h0000_1234};
    tbl[1]  = '{mk_load(8'h00, 2'b00, 32'h0000_1003, 32'h80FF_0000, 5'd6), 1'b1, 32'hFFFF_FF80};
    tbl[2]  = '{mk_load(8'h01, 2'b00, 32'h0000_1003, 32'h80FF_0000, 5'd7), 1'b1, 32'h0000_0080};
    tbl[3]  = '{mk_load(8'h00, 2'b01, 32'h0000_2002, 32'h80FF_0000, 5'd8), 1'b1, 32'hFFFF_80FF};
    tbl[4]  = '{mk_load(8'h01, 2'b01, 32'h0000_2002, 32'h80FF_0000, 5'd9), 1'b1, 32'h0000_80FF};
    tbl[5]  = '{mk_load(8'h00, 2'b10, 32'h0000_3001, 32'h80FF_0000, 5'd10), 1'b1, 32'h80FF_0000};
    tbl[6]  = '{mk_load(8'h01, 2'b00, 32'h0000_4000, 32'h1234_5678, 5'd11), 1'b1, 32'h0000_0078};
    tbl[7]  = '{mk_load(8'h00, 2'b00, 32'h0000_4001, 32'h1234_8678, 5'd12), 1'b1, 32'hFFFF_FF86};
    tbl[8]  = '{mk_load(8'h00, 2'b01, 32'h0000_5000, 32'h1234_7FFE, 5'd13), 1'b1, 32'h0000_7FFE};
    tbl[9]  = '{mk_alu(32'h0000_BEEF, 5'd0, 1'b1),                          1'b0, 32'h0};
    tbl[10] = '{mk_alu(32'h0000_CAFE, 5'd7, 1'b0),                          1'b0, 32'h0};
    tbl[11] = '{mk_load(8'h00, 2'b11, 32'h0000_6002, 32'hDEAD_BEEF, 5'd31), 1'b1, 32'hDEAD_BEEF};

    drive(idle);
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", ifc.wb_ready, 1);

    // back-to-back single-cycle instructions
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].b, tbl[i].exp_we, tbl[i].exp_wdata);
      tick();
      chk("ready_alu", ifc.wb_ready, 1);
    end
    drive(idle);
    tick();

    // CSR xchg, then a second CSR held on the bus during the stall
    a = mk_csr(14'h6, 32'h5555_5555, 32'h0000_FFFF, 5'd10, 1'b1);
    b = mk_csr(14'h6, 32'h1234_0000, 32'hFFFF_0000, 5'd9, 1'b1);
    issue(a, 1'b1, 32'hAAAA_AAAA);
    push_exp(1'b1, 5'd9, 32'hAAAA_5555);
    csr_run(14'h6, 1'b1, 32'hAAAA_5555, b);
    csr_run(14'h6, 1'b1, 32'h1234_5555, idle);

    // csrrd to x0 with a flushed instruction waiting behind it
    c  = mk_csr(14'h6, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b1);
    fl = mk_alu(32'h99, 5'd4, 1'b1);
    fl.flush = 1'b1;
    issue(c, 1'b0, 32'h0);
    csr_run(14'h6, 1'b0, 32'h0, fl);
    tick();
    chk("flush_cnt", retire_cnt, exp_cnt);
    drive(idle);
    tick();

    // read-only CSR into a real register
    issue(mk_csr(14'h2, 32'h0, 32'h0, 5'd3, 1'b1), 1'b1, 32'h1000_0002);
    csr_run(14'h2, 1'b0, 32'h0, idle);
    tick();

    // reset while the read is in flight
    drive(mk_csr(14'h6, 32'h0000_DEAD, 32'hFFFF_FFFF, 5'd8, 1'b1));
    tick();
    chk("mid_csr_re", csr_re, 1);
    drive(idle);
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = 64'd0;
    tick();
    chk_reset_state("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_csr_we", csr_we, 0);
      chk("post_rst_ready", ifc.wb_ready, 1);
    end

    // 16 retires wrap the 4-bit counter
    for (int i = 0; i < 15; i++) begin
      issue(mk_alu(32'h100 + 32'(i), 5'(i + 1), 1'b1), 1'b1, 32'h100 + 32'(i));
      tick();
    end
    chk("cnt4_max", retire_cnt4, 4'hF);
    issue(mk_alu(32'h0000_0777, 5'd20, 1'b1), 1'b1, 32'h0000_0777);
    tick();
    chk("cnt4_wrap", retire_cnt4, 4'h0);
    chk("cnt64_16", retire_cnt, 64'd16);
    drive(idle);
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
